// File: rtl/merge_pkg.sv
// Shared types and helpers for the merge_ctrl_stream merge node.
package merge_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [2:0] {
        MERGE   = 3'd0,
        DRAIN_A = 3'd1,
        DRAIN_B = 3'd2,
        PASS_A  = 3'd3,
        PASS_B  = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Key sits in the top KEY_W bits of the record; result is zero-extended.
    function automatic logic [MAX_W-1:0] key_of(input logic [MAX_W-1:0] rec,
                                                input int unsigned     data_w,
                                                input int unsigned     key_w);
        logic [MAX_W-1:0] mask;
        mask = (key_w >= MAX_W) ? '1 : ((MAX_W'(1) << key_w) - MAX_W'(1));
        return (rec >> (data_w - key_w)) & mask;
    endfunction

    // Ties favour A so equal keys keep their A-before-B order.
    function automatic logic a_wins(input logic [MAX_W-1:0] ka,
                                    input logic [MAX_W-1:0] kb,
                                    input logic             asc);
        return asc ? (ka <= kb) : (ka >= kb);
    endfunction

endpackage

// File: rtl/merge_out_stage.sv
// Single-entry output register for the merge node; holds its contents while
// the downstream stalls and reports when it can take a new record.
module merge_out_stage #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_adv
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;

    assign o_adv = ~r_valid | i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (o_adv) begin
            r_valid <= i_load;
            r_last  <= i_load & i_last;
            if (i_load) begin
                r_data <= i_data;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: rtl/merge_ctrl_stream.sv
// Two-input streaming merge node: merges run k of A with run k of B, closing
// each output run with one terminator, then passes through the longer stream.
module merge_ctrl_stream
    import merge_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned KEY_W     = 32,
    parameter logic [63:0] TERM_KEY  = '0,
    parameter bit          ASCENDING = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic              i_a_valid,
    input  logic              i_a_last,
    output logic              o_a_ready,
    input  logic [DATA_W-1:0] i_b_data,
    input  logic              i_b_valid,
    input  logic              i_b_last,
    output logic              o_b_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    input  logic              i_ready,
    output logic [CNT_W-1:0]  o_run_count,
    output logic              o_done,
    output logic              o_err
);

    state_t r_state, w_state_nxt, w_term_nxt;

    logic [MAX_W-1:0] w_key_a, w_key_b;
    logic             w_ta, w_tb, w_win_a, w_both;
    logic             w_adv;
    logic             w_take_a, w_take_b, w_emit, w_emit_b, w_out_last;
    logic             w_run_inc, w_term;
    logic [CNT_W-1:0] r_run_count;
    logic             r_err;

    assign w_key_a = key_of(MAX_W'(i_a_data), DATA_W, KEY_W);
    assign w_key_b = key_of(MAX_W'(i_b_data), DATA_W, KEY_W);
    assign w_ta    = (w_key_a == TERM_KEY);
    assign w_tb    = (w_key_b == TERM_KEY);
    assign w_win_a = a_wins(w_key_a, w_key_b, ASCENDING);
    assign w_both  = i_a_valid & i_b_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= MERGE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_term_nxt = MERGE;
        if (i_a_last & i_b_last) begin
            w_term_nxt = DONE;
        end else if (i_a_last) begin
            w_term_nxt = PASS_B;
        end else if (i_b_last) begin
            w_term_nxt = PASS_A;
        end
    end

    // A last=1 on a non-terminator ends that stream, so the other one is passed through.
    always_comb begin
        w_state_nxt = r_state;
        if (w_adv && w_emit) begin
            case (r_state)
                MERGE: begin
                    if (w_term) begin
                        w_state_nxt = w_term_nxt;
                    end else if (w_take_a) begin
                        w_state_nxt = i_a_last ? PASS_B : (w_tb ? DRAIN_A : MERGE);
                    end else begin
                        w_state_nxt = i_b_last ? PASS_A : (w_ta ? DRAIN_B : MERGE);
                    end
                end
                DRAIN_A: w_state_nxt = w_term ? w_term_nxt : (i_a_last ? PASS_B : DRAIN_A);
                DRAIN_B: w_state_nxt = w_term ? w_term_nxt : (i_b_last ? PASS_A : DRAIN_B);
                PASS_A:  w_state_nxt = i_a_last ? DONE : PASS_A;
                PASS_B:  w_state_nxt = i_b_last ? DONE : PASS_B;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_take_a   = 1'b0;
        w_take_b   = 1'b0;
        w_emit     = 1'b0;
        w_emit_b   = 1'b0;
        w_out_last = 1'b0;
        w_run_inc  = 1'b0;
        w_term     = 1'b0;
        case (r_state)
            MERGE: begin
                if (w_both) begin
                    if (w_ta & w_tb) begin
                        w_term = 1'b1;
                    end else if (w_tb | (~w_ta & w_win_a)) begin
                        w_take_a = 1'b1;
                        w_emit   = 1'b1;
                    end else begin
                        w_take_b = 1'b1;
                        w_emit   = 1'b1;
                        w_emit_b = 1'b1;
                    end
                end
            end
            DRAIN_A: begin
                if (i_a_valid & ~w_ta) begin
                    w_take_a = 1'b1;
                    w_emit   = 1'b1;
                end else if (w_both & w_ta & w_tb) begin
                    w_term = 1'b1;
                end
            end
            DRAIN_B: begin
                if (i_b_valid & ~w_tb) begin
                    w_take_b = 1'b1;
                    w_emit   = 1'b1;
                    w_emit_b = 1'b1;
                end else if (w_both & w_ta & w_tb) begin
                    w_term = 1'b1;
                end
            end
            PASS_A: begin
                if (i_a_valid) begin
                    w_take_a   = 1'b1;
                    w_emit     = 1'b1;
                    w_run_inc  = w_ta;
                    w_out_last = i_a_last;
                end
            end
            PASS_B: begin
                if (i_b_valid) begin
                    w_take_b   = 1'b1;
                    w_emit     = 1'b1;
                    w_emit_b   = 1'b1;
                    w_run_inc  = w_tb;
                    w_out_last = i_b_last;
                end
            end
            default: ;
        endcase
        if (w_term) begin
            w_take_a   = 1'b1;
            w_take_b   = 1'b1;
            w_emit     = 1'b1;
            w_run_inc  = 1'b1;
            w_out_last = i_a_last & i_b_last;
        end
    end

    assign o_a_ready = w_take_a & w_adv & ~i_rst;
    assign o_b_ready = w_take_b & w_adv & ~i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run_count <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_adv & w_run_inc) begin
                r_run_count <= r_run_count + CNT_W'(1);
            end
            if ((o_a_ready & i_a_last & ~w_ta) | (o_b_ready & i_b_last & ~w_tb)) begin
                r_err <= 1'b1;
            end
        end
    end

    merge_out_stage #(
        .DATA_W(DATA_W)
    ) u_out (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_emit),
        .i_data  (w_emit_b ? i_b_data : i_a_data),
        .i_last  (w_out_last),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_last  (o_last),
        .o_adv   (w_adv)
    );

    assign o_run_count = r_run_count;
    assign o_done      = (r_state == DONE);
    assign o_err       = r_err;

endmodule

// File: tb/tb_merge_ctrl_stream.sv
// Scoreboard bench for merge_ctrl_stream: three instances (8-bit ascending,
// 16/8-bit ascending, 8-bit descending) driven one at a time from queues.
module tb_merge_ctrl_stream;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] a_data [3];
    logic [15:0] b_data [3];
    logic        a_valid [3];
    logic        a_last [3];
    logic        b_valid [3];
    logic        b_last [3];
    logic        rdy_in [3];
    logic        a_ready [3];
    logic        b_ready [3];
    logic [15:0] o_data [3];
    logic        o_valid [3];
    logic        o_last [3];
    logic [15:0] run [3];
    logic        done [3];
    logic        err [3];
    logic [7:0]  od0, od2;

    assign o_data[0] = {8'h00, od0};
    assign o_data[2] = {8'h00, od2};

    rec_t qa[$];
    rec_t qb[$];
    rec_t qexp[$];
    int   checks = 0;
    int   errors = 0;
    int   nout   = 0;
    logic rdy    = 1'b1;

    merge_ctrl_stream #(.DATA_W(8), .KEY_W(8), .TERM_KEY(64'd0), .ASCENDING(1'b1), .CNT_W(16)) u_dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_a_data(a_data[0][7:0]), .i_a_valid(a_valid[0]), .i_a_last(a_last[0]), .o_a_ready(a_ready[0]),
        .i_b_data(b_data[0][7:0]), .i_b_valid(b_valid[0]), .i_b_last(b_last[0]), .o_b_ready(b_ready[0]),
        .o_data(od0), .o_valid(o_valid[0]), .o_last(o_last[0]), .i_ready(rdy_in[0]),
        .o_run_count(run[0]), .o_done(done[0]), .o_err(err[0]));

    merge_ctrl_stream #(.DATA_W(16), .KEY_W(8), .TERM_KEY(64'd0), .ASCENDING(1'b1), .CNT_W(16)) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_a_data(a_data[1]), .i_a_valid(a_valid[1]), .i_a_last(a_last[1]), .o_a_ready(a_ready[1]),
        .i_b_data(b_data[1]), .i_b_valid(b_valid[1]), .i_b_last(b_last[1]), .o_b_ready(b_ready[1]),
        .o_data(o_data[1]), .o_valid(o_valid[1]), .o_last(o_last[1]), .i_ready(rdy_in[1]),
        .o_run_count(run[1]), .o_done(done[1]), .o_err(err[1]));

    merge_ctrl_stream #(.DATA_W(8), .KEY_W(8), .TERM_KEY(64'd0), .ASCENDING(1'b0), .CNT_W(16)) u_dut2 (
        .i_clk(clk), .i_rst(rst),
        .i_a_data(a_data[2][7:0]), .i_a_valid(a_valid[2]), .i_a_last(a_last[2]), .o_a_ready(a_ready[2]),
        .i_b_data(b_data[2][7:0]), .i_b_valid(b_valid[2]), .i_b_last(b_last[2]), .o_b_ready(b_ready[2]),
        .o_data(od2), .o_valid(o_valid[2]), .o_last(o_last[2]), .i_ready(rdy_in[2]),
        .o_run_count(run[2]), .o_done(done[2]), .o_err(err[2]));

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            a_valid[i] = 1'b0; a_data[i] = '0; a_last[i] = 1'b0;
            b_valid[i] = 1'b0; b_data[i] = '0; b_last[i] = 1'b0;
            rdy_in[i]  = 1'b1;
        end
    endtask

    task automatic push_a(input logic [15:0] d, input logic l);
        rec_t r; r.d = d; r.l = l; qa.push_back(r);
    endtask
    task automatic push_b(input logic [15:0] d, input logic l);
        rec_t r; r.d = d; r.l = l; qb.push_back(r);
    endtask
    task automatic push_e(input logic [15:0] d, input logic l);
        rec_t r; r.d = d; r.l = l; qexp.push_back(r);
    endtask

    task automatic apply_reset();
        qa.delete(); qb.delete(); qexp.delete();
        nout = 0;
        rdy  = 1'b1;
        @(negedge clk);
        idle_all();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: present queue heads, check any accepted output, retire consumed heads.
    task automatic drive_cycle(input int d);
        rec_t e;
        @(negedge clk);
        if (qa.size() > 0) begin
            a_valid[d] = 1'b1; a_data[d] = qa[0].d; a_last[d] = qa[0].l;
        end else begin
            a_valid[d] = 1'b0; a_data[d] = '0; a_last[d] = 1'b0;
        end
        if (qb.size() > 0) begin
            b_valid[d] = 1'b1; b_data[d] = qb[0].d; b_last[d] = qb[0].l;
        end else begin
            b_valid[d] = 1'b0; b_data[d] = '0; b_last[d] = 1'b0;
        end
        rdy_in[d] = rdy;
        #1;
        if (o_valid[d] && rdy) begin
            checks++;
            if (qexp.size() == 0) begin
                errors++;
                $display("FAIL extra_output dut%0d got %h expected none", d, o_data[d]);
            end else begin
                e = qexp.pop_front();
                nout++;
                if (o_data[d] !== e.d || o_last[d] !== e.l) begin
                    errors++;
                    $display("FAIL out_record dut%0d #%0d got %h last=%b expected %h last=%b",
                             d, nout, o_data[d], o_last[d], e.d, e.l);
                end
                checks++;
                if (done[d] !== e.l) begin
                    errors++;
                    $display("FAIL done_timing dut%0d #%0d got %b expected %b", d, nout, done[d], e.l);
                end
            end
        end
        if (a_ready[d] && qa.size() > 0) void'(qa.pop_front());
        if (b_ready[d] && qb.size() > 0) void'(qb.pop_front());
    endtask

    task automatic run_until_empty(input int d, input int budget);
        int c = 0;
        while (qexp.size() > 0 && c < budget) begin
            drive_cycle(d);
            c++;
        end
        checks++;
        if (qexp.size() != 0 || qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout dut%0d got exp/a/b left %0d/%0d/%0d expected 0/0/0",
                     d, qexp.size(), qa.size(), qb.size());
        end
    endtask

    task automatic load_test1();
        push_a(16'd3, 1'b0); push_a(16'd7, 1'b0); push_a(16'd0, 1'b1);
        push_b(16'd5, 1'b0); push_b(16'd9, 1'b0); push_b(16'd0, 1'b1);
        push_e(16'd3, 1'b0); push_e(16'd5, 1'b0); push_e(16'd7, 1'b0);
        push_e(16'd9, 1'b0); push_e(16'd0, 1'b1);
    endtask

    task automatic test_reset();
        qa.delete(); qb.delete(); qexp.delete();
        @(negedge clk);
        idle_all();
        rst = 1'b1;
        a_valid[0] = 1'b1; a_data[0] = 16'd3;
        b_valid[0] = 1'b1; b_data[0] = 16'd5;
        @(negedge clk);
        #1;
        checks++;
        if (a_ready[0] !== 1'b0 || b_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset got %b%b expected 00", a_ready[0], b_ready[0]);
        end
        @(negedge clk);
        idle_all();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_valid[i] !== 1'b0 || o_last[i] !== 1'b0 || o_data[i] !== 16'h0 ||
                run[i] !== 16'h0 || done[i] !== 1'b0 || err[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d got v=%b l=%b d=%h run=%0d done=%b err=%b expected all 0",
                         i, o_valid[i], o_last[i], o_data[i], run[i], done[i], err[i]);
            end
        end
    endtask

    task automatic test_basic();
        apply_reset();
        load_test1();
        run_until_empty(0, 40);
        checks++;
        if (run[0] !== 16'd1 || done[0] !== 1'b1 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_status got run=%0d done=%b err=%b expected 1 1 0", run[0], done[0], err[0]);
        end
        drive_cycle(0);
        checks++;
        if (o_valid[0] !== 1'b0 || done[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_after got valid=%b done=%b expected 0 1", o_valid[0], done[0]);
        end
    endtask

    task automatic test_ties();
        apply_reset();
        push_a(16'h04AA, 1'b0); push_a(16'h0000, 1'b1);
        push_b(16'h0455, 1'b0); push_b(16'h0000, 1'b1);
        push_e(16'h04AA, 1'b0); push_e(16'h0455, 1'b0); push_e(16'h0000, 1'b1);
        run_until_empty(1, 30);
        checks++;
        if (run[1] !== 16'd1) begin
            errors++;
            $display("FAIL ties_run got %0d expected 1", run[1]);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        load_test1();
        drive_cycle(0);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(0);
            checks++;
            if (o_valid[0] !== 1'b1 || o_data[0] !== 16'd3 || a_ready[0] !== 1'b0 || b_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc%0d got v=%b d=%h ra=%b rb=%b expected 1 03 0 0",
                         k, o_valid[0], o_data[0], a_ready[0], b_ready[0]);
            end
        end
        rdy = 1'b1;
        run_until_empty(0, 40);
        checks++;
        if (run[0] !== 16'd1 || nout !== 5) begin
            errors++;
            $display("FAIL stall_total got run=%0d outs=%0d expected 1 5", run[0], nout);
        end
    endtask

    task automatic test_unequal();
        int  c    = 0;
        bit  seen = 0;
        apply_reset();
        push_a(16'd1, 1'b0); push_a(16'd0, 1'b0); push_a(16'd2, 1'b0); push_a(16'd0, 1'b1);
        push_b(16'd3, 1'b0); push_b(16'd0, 1'b1);
        push_e(16'd1, 1'b0); push_e(16'd3, 1'b0); push_e(16'd0, 1'b0);
        push_e(16'd2, 1'b0); push_e(16'd0, 1'b1);
        while (qexp.size() > 0 && c < 40) begin
            drive_cycle(0);
            c++;
            if (nout == 3 && !seen) begin
                seen = 1;
                checks++;
                if (run[0] !== 16'd1 || done[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL first_term got run=%0d done=%b expected 1 0", run[0], done[0]);
                end
            end
        end
        checks++;
        if (qexp.size() != 0 || run[0] !== 16'd2 || done[0] !== 1'b1) begin
            errors++;
            $display("FAIL unequal_end got left=%0d run=%0d done=%b expected 0 2 1", qexp.size(), run[0], done[0]);
        end
    endtask

    task automatic test_descending();
        apply_reset();
        push_a(16'd9, 1'b0); push_a(16'd2, 1'b0); push_a(16'd0, 1'b1);
        push_b(16'd5, 1'b0); push_b(16'd0, 1'b1);
        push_e(16'd9, 1'b0); push_e(16'd5, 1'b0); push_e(16'd2, 1'b0); push_e(16'd0, 1'b1);
        run_until_empty(2, 30);
        checks++;
        if (run[2] !== 16'd1 || done[2] !== 1'b1) begin
            errors++;
            $display("FAIL desc_status got run=%0d done=%b expected 1 1", run[2], done[2]);
        end
    endtask

    task automatic test_error();
        apply_reset();
        push_a(16'd4, 1'b1);
        push_b(16'd5, 1'b0); push_b(16'd0, 1'b1);
        push_e(16'd4, 1'b0); push_e(16'd5, 1'b0); push_e(16'd0, 1'b1);
        run_until_empty(0, 30);
        checks++;
        if (err[0] !== 1'b1 || run[0] !== 16'd1 || done[0] !== 1'b1) begin
            errors++;
            $display("FAIL error_flag got err=%b run=%0d done=%b expected 1 1 1", err[0], run[0], done[0]);
        end
    endtask

    task automatic test_reset_midstream();
        int c = 0;
        apply_reset();
        push_a(16'd3, 1'b1);
        push_b(16'd5, 1'b0); push_b(16'd9, 1'b0); push_b(16'd0, 1'b1);
        push_e(16'd3, 1'b0); push_e(16'd5, 1'b0); push_e(16'd9, 1'b0); push_e(16'd0, 1'b1);
        while (nout < 2 && c < 30) begin
            drive_cycle(0);
            c++;
        end
        checks++;
        if (nout != 2 || err[0] !== 1'b1 || o_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got outs=%0d err=%b valid=%b expected 2 1 1", nout, err[0], o_valid[0]);
        end
        apply_reset();
        #1;
        checks++;
        if (o_valid[0] !== 1'b0 || run[0] !== 16'd0 || err[0] !== 1'b0 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b run=%0d err=%b done=%b expected 0 0 0 0",
                     o_valid[0], run[0], err[0], done[0]);
        end
        test_basic();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_basic();
        test_ties();
        test_backpressure();
        test_unequal();
        test_descending();
        test_error();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/merge_ctrl_stream.md
Name: merge_ctrl_stream

Overview:
Parametrised 2-to-1 merge controller and datapath for the Bonsai merge tree. It replaces the fixed full/empty/min-zero control with valid/ready streams on both inputs and the output. Each input carries sorted runs separated by terminator records (key == TERM_KEY). Run k of A is merged with run k of B into one output run, closed by a single terminator.
- Adds runtime sort direction, stable tie-breaking, end-of-stream pass-through, a run counter and protocol-error flagging.

Parameters:
DATA_W, 32, total record width
KEY_W, 32, key width; key = record[DATA_W-1 -: KEY_W]; KEY_W <= DATA_W
TERM_KEY, 0, key value marking end of run
ASCENDING, 1, 1 = smallest key first; 0 = largest key first
CNT_W, 16, width of run counter

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_a_data  in  DATA_W  head record of stream A
i_a_valid  in  1  A head valid
i_a_last  in  1  A head is final record of stream A
o_a_ready  out  1  A head consumed this cycle
i_b_data, i_b_valid, i_b_last, o_b_ready  (same as A, for stream B)
o_data  out  DATA_W  merged record (registered)
o_valid  out  1  o_data valid
o_last  out  1  final record of merged stream
i_ready  in  1  downstream accepts o_data
o_run_count  out  CNT_W  terminators emitted since reset (wraps)
o_done  out  1  final terminator emitted; sticky until reset
o_err  out  1  sticky: input had last=1 on a non-terminator record

Behaviour:
- Reset (synchronous, i_rst=1 at rising edge):
  - state=MERGE; o_valid=0, o_last=0, o_done=0, o_err=0, o_run_count=0, o_data=0.
  - o_a_ready=o_b_ready=0 while i_rst=1.
  - Reset mid-stream discards the in-flight output record and all state.
- Output stage is a single register. adv = ~o_valid | i_ready.
  - Records are consumed only when adv=1. Latency: input consumed in cycle N appears on o_data in cycle N+1.
  - o_data, o_valid and o_last are held stable while o_valid & ~i_ready.
  - If nothing is emitted and adv=1, o_valid falls.
- Head classification: tA = (key(A) == TERM_KEY); tB likewise. The direction comparison uses unsigned keys.
  - win_A = ASCENDING ? keyA <= keyB : keyA >= keyB.
  - Ties go to A (stable).
- States:
  - MERGE, when both heads are valid:
    - neither is a terminator: emit and consume the winner.
    - tB only: emit/consume A, go DRAIN_A.
    - tA only: emit/consume B, go DRAIN_B.
    - both terminators: go to TERM handling (below).
    - If either head is invalid, stall: no consume, no emit.
  - DRAIN_A: forward A non-terminators; B is not consumed. When A head is a terminator, do TERM handling.
  - DRAIN_B: symmetric to DRAIN_A.
  - TERM handling (requires both heads valid and both terminators):
    - Consume both heads; emit one terminator (A's record); o_run_count++.
    - o_last = a_last & b_last.
    - Next state: both last -> DONE; a_last only -> PASS_B; b_last only -> PASS_A; neither -> MERGE.
  - PASS_A: forward A records verbatim, including terminators.
    - o_run_count++ per terminator forwarded.
    - On forwarding a record with a_last: o_last=1, go DONE.
  - PASS_B: symmetric to PASS_A.
  - DONE: readies 0, no emits. o_done=1 from the cycle the final record is registered. Only reset exits DONE.
- Simultaneous events:
  - Both readies may assert only in TERM handling.
  - The o_run_count increment and the o_done set occur in the same cycle as the final terminator is registered.
- o_err is set when a consumed record has last=1 and is not a terminator. That record is then treated as its stream's end, with no extra terminator synthesised.
- o_run_count wraps modulo 2^CNT_W.

Decomposition:
- Package merge_pkg holds:
  - state enum {MERGE, DRAIN_A, DRAIN_B, PASS_A, PASS_B, DONE} (3 bits);
  - the key-extract function;
  - the direction compare function.
- Sub-module merge_out_stage holds the output register with hold-on-stall, plus its adv output.

Test Plan:
- Config: DATA_W=KEY_W=8, TERM_KEY=0, i_ready=1 unless stated.
1. A=3,7,0(last); B=5,9,0(last) -> o_data 3,5,7,9,0; o_last only on 0; o_run_count=1; o_done=1 the cycle after.
2. Ties (DATA_W=16, KEY_W=8): A=0x04AA,0x0000(last); B=0x0455,0x0000(last) -> 0x04AA before 0x0455.
3. Backpressure: stimulus as test 1, with i_ready=0 for 3 cycles after first output -> o_data=3 held, o_a_ready/o_b_ready=0, no loss; full sequence intact after release.
4. Unequal runs: A=1,0,2,0(last); B=3,0(last) -> 1,3,0,2,0(o_last); PASS_A entered after the first terminator; o_run_count=2.
5. ASCENDING=0: A=9,2,0(last); B=5,0(last) -> 9,5,2,0.
6. Error and reset: A=4(last, non-terminator) -> o_err=1. Reset after 2 outputs of test 1 -> next cycle o_valid=0, o_run_count=0, o_err=0. Rerunning test 1 passes.
